// File: rtl/reg_file.sv
// Architectural register file with rename tags for a Tomasulo-style core.
// Operand reads resolve in zero cycles, forwarding from commit, the CDBs or the ROB.
`ifndef ROB_WIDTH
`define ROB_WIDTH 3
`endif

module reg_file (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  clear,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   output logic [31:0]           val_j,
   output logic [31:0]           val_k,
   output logic                  has_dep_j,
   output logic                  has_dep_k,
   output logic [`ROB_WIDTH-1:0] dep_j,
   output logic [`ROB_WIDTH-1:0] dep_k,
   input  logic                  rename_en,
   input  logic [4:0]            rename_rd,
   input  logic [`ROB_WIDTH-1:0] rename_rob_id,
   input  logic                  commit_en,
   input  logic [4:0]            commit_rd,
   input  logic [`ROB_WIDTH-1:0] commit_rob_id,
   input  logic [31:0]           commit_value,
   input  logic                  rs_ready,
   input  logic [`ROB_WIDTH-1:0] rs_rob_id,
   input  logic [31:0]           rs_value,
   input  logic                  lsb_ready,
   input  logic [`ROB_WIDTH-1:0] lsb_rob_id,
   input  logic [31:0]           lsb_value,
   input  logic                  rob_j_ready,
   input  logic [31:0]           rob_j_value,
   input  logic                  rob_k_ready,
   input  logic [31:0]           rob_k_value
);

   typedef struct packed {
      logic [31:0]           val;
      logic                  has_dep;
      logic [`ROB_WIDTH-1:0] dep;
   } operand_t;

   logic [31:0]           value_q [32];
   logic [31:0]           value_d [32];
   logic [31:0]           busy_q;
   logic [31:0]           busy_d;
   logic [`ROB_WIDTH-1:0] tag_q [32];
   logic [`ROB_WIDTH-1:0] tag_d [32];

   logic rename_fire;
   logic commit_fire;

   assign rename_fire = rdy_in && rename_en && !clear && (rename_rd != 5'd0);
   assign commit_fire = rdy_in && commit_en && (commit_rd != 5'd0);

   // Priority: commit, ALU CDB, LSB CDB, then the ROB's own lookup.
   function automatic operand_t resolve(
      input logic [4:0]            idx,
      input logic [31:0]           st_val,
      input logic                  st_busy,
      input logic [`ROB_WIDTH-1:0] st_tag,
      input logic                  rob_ready,
      input logic [31:0]           rob_value
   );
      operand_t r;
      r = '0;
      if (idx == 5'd0) begin
         r = '0;
      end else if (!st_busy) begin
         r.val = st_val;
      end else begin
         r.dep = st_tag;
         if (commit_en && commit_rd == idx && commit_rob_id == st_tag) begin
            r.val = commit_value;
         end else if (rs_ready && rs_rob_id == st_tag) begin
            r.val = rs_value;
         end else if (lsb_ready && lsb_rob_id == st_tag) begin
            r.val = lsb_value;
         end else if (rob_ready) begin
            r.val = rob_value;
         end else begin
            r.has_dep = 1'b1;
         end
      end
      return r;
   endfunction

   operand_t op_j;
   operand_t op_k;

   always_comb begin
      op_j = resolve(rs1, value_q[rs1], busy_q[rs1], tag_q[rs1], rob_j_ready, rob_j_value);
      op_k = resolve(rs2, value_q[rs2], busy_q[rs2], tag_q[rs2], rob_k_ready, rob_k_value);
   end

   assign val_j     = op_j.val;
   assign has_dep_j = op_j.has_dep;
   assign dep_j     = op_j.dep;
   assign val_k     = op_k.val;
   assign has_dep_k = op_k.has_dep;
   assign dep_k     = op_k.dep;

   // A same-cycle rename is applied after the commit so the newer producer keeps busy.
   always_comb begin
      for (int i = 0; i < 32; i++) begin
         value_d[i] = value_q[i];
         tag_d[i]   = tag_q[i];
      end
      busy_d = busy_q;
      if (commit_fire) begin
         value_d[commit_rd] = commit_value;
         if (tag_q[commit_rd] == commit_rob_id) busy_d[commit_rd] = 1'b0;
      end
      if (rdy_in && clear) begin
         busy_d = '0;
         for (int i = 0; i < 32; i++) tag_d[i] = '0;
      end
      if (rename_fire) begin
         busy_d[rename_rd] = 1'b1;
         tag_d[rename_rd]  = rename_rob_id;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < 32; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         busy_q <= '0;
      end else begin
         for (int i = 0; i < 32; i++) begin
            value_q[i] <= value_d[i];
            tag_q[i]   <= tag_d[i];
         end
         busy_q <= busy_d;
      end
   end

endmodule
